mpi_stream_depacketizer: RTL and testbench

- Synthesizable receive-side counterpart to the MPI stream driver.
- Accepts a 64-bit AXI-Stream carrying one MPI packet per burst: two header flits, then payload flits.
- Extracts the header fields into a registered header record with a valid/ready handshake.
- Forwards the payload as a clean AXI-Stream and checks the payload length against the header size field.
- Sits between the network-side stream (after MAC/IP stripping) and the MPI kernel interface.

---
 rtl/mpi_stream_pkg.sv | 33 +++
 rtl/keep_popcount.sv | 17 +
 rtl/mpi_stream_depacketizer.sv | 193 +++++++++++++++++++
 tb/tb_mpi_stream_depacketizer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpi_stream_pkg.sv
// Shared types and header layout for the MPI stream transmit/receive blocks.
package mpi_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR_OUT,
    ST_PAY,
    ST_DRAIN
  } state_t;

  // Flit 0 field placement
  localparam int DST_LSB  = 0;
  localparam int DST_W    = 16;
  localparam int SRC_LSB  = 16;
  localparam int SRC_W    = 8;
  localparam int TYPE_LSB = 24;
  localparam int TYPE_W   = 8;
  localparam int SIZE_LSB = 32;
  localparam int SIZE_W   = 32;
  // Flit 1 field placement; bits above the tag are reserved
  localparam int TAG_LSB  = 0;
  localparam int TAG_W    = 8;

  typedef struct packed {
    logic [DST_W-1:0]  dst_rank;
    logic [SRC_W-1:0]  src_rank;
    logic [TYPE_W-1:0] packet_type;
    logic [SIZE_W-1:0] size;
    logic [TAG_W-1:0]  tag;
  } mpi_hdr_t;

endpackage

// File: rtl/keep_popcount.sv
// Counts asserted byte enables of one 64-bit flit.
module keep_popcount (
  input  logic [7:0] keep,
  output logic [3:0] count
);

  // Sum the individual enable bits
  always_comb begin
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'b000, keep[i]};
    end
    count = acc;
  end

endmodule

// File: rtl/mpi_stream_depacketizer.sv
// Receive-side MPI depacketizer: peels the two header flits into a
// handshaked header record and passes the payload straight through,
// checking its byte count against the header size field.
import mpi_stream_pkg::*;

module mpi_stream_depacketizer #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [15:0]       hdr_dst_rank,
  output logic [7:0]        hdr_src_rank,
  output logic [7:0]        hdr_packet_type,
  output logic [31:0]       hdr_size,
  output logic [7:0]        hdr_tag,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err_runt,
  output logic              err_len,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  function automatic logic [31:0] sat_add_bytes(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t     state, state_nxt;
  mpi_hdr_t   hdr_reg;
  logic       hdr_only, hdr_only_nxt;
  logic [31:0] byte_cnt, byte_sum;
  logic [3:0] keep_cnt;
  logic       s_ready_c, m_valid_c;
  logic       cap_f0, cap_tag, hdr_accept, pay_fire, pay_end;
  logic       set_runt, set_len;
  logic       in_pay;

  keep_popcount u_keep_popcount (
    .keep  (s_keep),
    .count (keep_cnt)
  );

  assign byte_sum = sat_add_bytes(byte_cnt, keep_cnt);
  assign in_pay   = (state == ST_PAY);

  // Next-state and handshake decode
  always_comb begin
    state_nxt    = state;
    hdr_only_nxt = hdr_only;
    s_ready_c    = 1'b0;
    m_valid_c    = 1'b0;
    cap_f0       = 1'b0;
    cap_tag      = 1'b0;
    hdr_accept   = 1'b0;
    pay_fire     = 1'b0;
    pay_end      = 1'b0;
    set_runt     = 1'b0;
    set_len      = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          cap_f0 = 1'b1;
          if (s_last) set_runt  = 1'b1;
          else        state_nxt = ST_HDR1;
        end
      end
      ST_HDR1: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          cap_tag = 1'b1;
          if (s_last) begin
            if (hdr_reg.size != 32'd0) begin
              set_runt  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              hdr_only_nxt = 1'b1;
              state_nxt    = ST_HDR_OUT;
            end
          end else if (hdr_reg.size == 32'd0) begin
            set_len   = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            hdr_only_nxt = 1'b0;
            state_nxt    = ST_HDR_OUT;
          end
        end
      end
      ST_HDR_OUT: begin
        if (hdr_ready) begin
          hdr_accept = 1'b1;
          state_nxt  = hdr_only ? ST_IDLE : ST_PAY;
        end
      end
      ST_PAY: begin
        s_ready_c = m_ready;
        m_valid_c = s_valid;
        if (s_valid && m_ready) begin
          pay_fire = 1'b1;
          if (s_last) begin
            pay_end   = 1'b1;
            set_len   = (byte_sum != hdr_reg.size);
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        s_ready_c = 1'b1;
        if (s_valid && s_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready         = s_ready_c & ~rst;
  assign m_valid         = m_valid_c;
  assign m_data          = in_pay ? s_data : '0;
  assign m_keep          = in_pay ? s_keep : '0;
  assign m_last          = in_pay ? s_last : 1'b0;
  assign hdr_valid       = (state == ST_HDR_OUT);
  assign hdr_dst_rank    = hdr_reg.dst_rank;
  assign hdr_src_rank    = hdr_reg.src_rank;
  assign hdr_packet_type = hdr_reg.packet_type;
  assign hdr_size        = hdr_reg.size;
  assign hdr_tag         = hdr_reg.tag;

  // State register and header-only flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr_only <= 1'b0;
    end else begin
      state    <= state_nxt;
      hdr_only <= hdr_only_nxt;
    end
  end

  // Header field capture from flit 0 and flit 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_reg <= '0;
    end else begin
      if (cap_f0) begin
        hdr_reg.dst_rank    <= s_data[DST_LSB +: DST_W];
        hdr_reg.src_rank    <= s_data[SRC_LSB +: SRC_W];
        hdr_reg.packet_type <= s_data[TYPE_LSB +: TYPE_W];
        hdr_reg.size        <= s_data[SIZE_LSB +: SIZE_W];
      end
      if (cap_tag) hdr_reg.tag <= s_data[TAG_LSB +: TAG_W];
    end
  end

  // Running payload byte count, cleared at the end of each payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           byte_cnt <= '0;
    else if (pay_end)  byte_cnt <= '0;
    else if (pay_fire) byte_cnt <= byte_sum;
  end

  // Error pulses and saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_runt  <= 1'b0;
      err_len   <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      err_runt <= set_runt;
      err_len  <= set_len;
      if (hdr_accept)         pkt_count <= sat_inc(pkt_count);
      if (set_runt | set_len) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_mpi_stream_depacketizer.sv
// Scoreboard bench for mpi_stream_depacketizer.
module tb_mpi_stream_depacketizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last, s_valid, s_ready;
  logic [15:0] hdr_dst_rank;
  logic [7:0]  hdr_src_rank, hdr_packet_type, hdr_tag;
  logic [31:0] hdr_size;
  logic        hdr_valid, hdr_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last, m_valid, m_ready;
  logic        err_runt, err_len;
  logic [15:0] pkt_count, err_count;

  always #5 clk = ~clk;

  mpi_stream_depacketizer dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .hdr_dst_rank(hdr_dst_rank), .hdr_src_rank(hdr_src_rank), .hdr_packet_type(hdr_packet_type),
    .hdr_size(hdr_size), .hdr_tag(hdr_tag), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .err_runt(err_runt), .err_len(err_len), .pkt_count(pkt_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  int rdy_mode = 0;
  int hv_cycles = 0;

  logic [71:0] hdr_q[$];
  logic [72:0] pay_q[$];
  int          err_q[$];
  logic [63:0] pk_d[$];
  logic [7:0]  pk_k[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) chk("s_ready_in_hdr_out", s_ready, 0);
      if (hdr_valid && hdr_ready) begin
        if (hdr_q.size() == 0) fail("hdr_unexpected");
        else chk("hdr_fields", {hdr_dst_rank, hdr_src_rank, hdr_packet_type, hdr_size, hdr_tag},
                 hdr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        if (pay_q.size() == 0) fail("payload_unexpected");
        else chk("payload", {m_last, m_keep, m_data}, pay_q.pop_front());
      end
      if (err_runt) begin
        if (err_q.size() == 0) fail("err_runt_unexpected");
        else chk("err_kind_runt", 1, err_q.pop_front());
      end
      if (err_len) begin
        if (err_q.size() == 0) fail("err_len_unexpected");
        else chk("err_kind_len", 2, err_q.pop_front());
      end
    end
  end

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin hdr_ready = 1'b1; m_ready = 1'b1; end
      1: begin hdr_ready = 1'($urandom_range(0, 1)); m_ready = 1'($urandom_range(0, 1)); end
      default: begin
        hv_cycles = hdr_valid ? hv_cycles + 1 : 0;
        hdr_ready = (hv_cycles > 5);
        m_ready   = ~m_ready;
      end
    endcase
  end

  task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail("send_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic hdr_flits(input logic [15:0] dst, input logic [7:0] src, input logic [7:0] typ,
                           input logic [31:0] size, input logic [7:0] tag);
    logic [63:0] f1;
    f1 = {$urandom, $urandom};
    f1[7:0] = tag;
    pk_d.push_back({size, typ, src, dst});
    pk_k.push_back(8'hFF);
    pk_d.push_back(f1);
    pk_k.push_back(8'hFF);
  endtask

  task automatic pay(input logic [7:0] k);
    pk_d.push_back({$urandom, $urandom});
    pk_k.push_back(k);
  endtask

  // Reference model: derive expectations for the queued packet, then send it
  task automatic run_packet();
    int n;
    int bytes;
    logic [31:0] size;
    n = pk_d.size();
    size = pk_d[0][63:32];
    bytes = 0;
    if (n == 1 || (n == 2 && size != 0)) begin
      err_q.push_back(1);
      exp_err++;
    end else if (n > 2 && size == 0) begin
      err_q.push_back(2);
      exp_err++;
    end else begin
      hdr_q.push_back({pk_d[0][15:0], pk_d[0][23:16], pk_d[0][31:24], size, pk_d[1][7:0]});
      exp_pkt++;
      for (int i = 2; i < n; i++) begin
        pay_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, pk_k[i], pk_d[i]});
        bytes += $countones(pk_k[i]);
      end
      if (n > 2 && bytes != int'(size)) begin
        err_q.push_back(2);
        exp_err++;
      end
    end
    for (int i = 0; i < n; i++) send_flit(pk_d[i], pk_k[i], (i == n - 1) ? 1'b1 : 1'b0);
    pk_d.delete();
    pk_k.delete();
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((hdr_q.size() + pay_q.size() + err_q.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if ((hdr_q.size() + pay_q.size() + err_q.size()) != 0) begin
      fail({tag, "_drain_timeout"});
      hdr_q.delete(); pay_q.delete(); err_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pkt_count"}, pkt_count, exp_pkt);
    chk({tag, "_err_count"}, err_count, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0;
    hdr_ready = 1'b0; m_ready = 1'b0;
    #2;
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_hdr_size", hdr_size, 0);
    chk("rst_counts", {pkt_count, err_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_s_ready", s_ready, 1);

    // Nominal packet
    hdr_flits(16'd3, 8'd1, 8'h02, 32'd20, 8'h07);
    pay(8'hFF); pay(8'hFF); pay(8'h0F);
    run_packet();
    wait_quiet("nominal");

    // Header and payload backpressure
    rdy_mode = 2;
    hdr_flits(16'd9, 8'd4, 8'h11, 32'd24, 8'h33);
    pay(8'hFF); pay(8'hFF); pay(8'hFF);
    run_packet();
    wait_quiet("backpressure");
    rdy_mode = 0;

    // Length mismatch
    hdr_flits(16'd5, 8'd2, 8'h03, 32'd16, 8'h01);
    pay(8'hFF); pay(8'hFF); pay(8'hFF);
    run_packet();
    wait_quiet("len_mismatch");
    chk("len_mismatch_idle_hdr_valid", hdr_valid, 0);
    chk("len_mismatch_idle_s_ready", s_ready, 1);

    // Runt followed by a good packet
    pk_d.push_back({32'd8, 8'h01, 8'h02, 16'h0004});
    pk_k.push_back(8'hFF);
    run_packet();
    hdr_flits(16'd7, 8'd6, 8'h05, 32'd8, 8'h0A);
    pay(8'hFF);
    run_packet();
    wait_quiet("runt");

    // Zero-size header-only, then zero-size with trailing flits drained
    hdr_flits(16'd1, 8'd1, 8'h04, 32'd0, 8'h02);
    run_packet();
    hdr_flits(16'd2, 8'd2, 8'h04, 32'd0, 8'h03);
    pay(8'hFF); pay(8'h03);
    run_packet();
    wait_quiet("zero_size");

    // Randomized packets with random downstream readiness
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int n;
      int sum;
      int mode;
      logic [7:0] ks[$];
      logic [31:0] size;
      n = $urandom_range(1, 6);
      sum = 0;
      for (int i = 2; i < n; i++) begin
        ks.push_back(8'($urandom_range(0, 255)));
        sum += $countones(ks[ks.size() - 1]);
      end
      mode = $urandom_range(0, 3);
      size = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(0, 50)) : 32'(sum);
      hdr_flits(16'($urandom), 8'($urandom), 8'($urandom), size, 8'($urandom));
      for (int i = 0; i < ks.size(); i++) begin
        pk_d.push_back({$urandom, $urandom});
        pk_k.push_back(ks[i]);
      end
      if (n == 1) begin
        pk_d.pop_back();
        pk_k.pop_back();
      end
      run_packet();
    end
    wait_quiet("random");
    rdy_mode = 0;

    // Asynchronous reset in the middle of a payload
    hdr_flits(16'd3, 8'd1, 8'h02, 32'd32, 8'h07);
    hdr_q.push_back({16'd3, 8'd1, 8'h02, 32'd32, pk_d[1][7:0]});
    send_flit(pk_d[0], 8'hFF, 1'b0);
    send_flit(pk_d[1], 8'hFF, 1'b0);
    pay_q.push_back({1'b0, 8'hFF, 64'h1111_2222_3333_4444});
    send_flit(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    pk_d.delete(); pk_k.delete();
    s_data = 64'h5555_6666_7777_8888; s_keep = 8'hFF; s_last = 1'b0; s_valid = 1'b1;
    #1;
    chk("pre_rst_m_valid", m_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_m_data", m_data, 0);
    chk("async_rst_hdr_valid", hdr_valid, 0);
    chk("async_rst_hdr_fields", {hdr_dst_rank, hdr_src_rank, hdr_packet_type, hdr_size, hdr_tag}, 0);
    chk("async_rst_counts", {pkt_count, err_count}, 0);
    chk("async_rst_err_pulses", {err_runt, err_len}, 0);
    chk("async_rst_s_ready", s_ready, 0);
    chk("async_rst_queues_drained", hdr_q.size() + pay_q.size(), 0);
    s_valid = 1'b0;
    hdr_q.delete(); pay_q.delete(); err_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_async_rst_s_ready", s_ready, 1);
    hdr_flits(16'd3, 8'd1, 8'h02, 32'd20, 8'h07);
    pay(8'hFF); pay(8'hFF); pay(8'h0F);
    run_packet();
    wait_quiet("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
